// File: rtl/sap1_accumulator_stage_if.sv
// Signal bundle between the SAP-1 accumulator stage, the W-bus and the external adder.
// The sub port exists only when SAP1_ACC_SUBTRACT_EN is defined.
interface sap1_accumulator_stage_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] bus_in;
  logic             load_a;
  logic             load_b;
  logic             add_start;
  logic             out_en;
  logic [WIDTH-1:0] adder_s;
  logic             adder_carry;
`ifdef SAP1_ACC_SUBTRACT_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic [WIDTH-1:0] bus_out;
  logic             bus_drive;
  logic [WIDTH-1:0] acc;
  logic             carry_flag;
  logic             zero_flag;
  logic             busy;
  logic             done;

`ifdef SAP1_ACC_SUBTRACT_EN
  modport master (
    output bus_in, load_a, load_b, add_start, out_en, adder_s, adder_carry, sub,
    input  adder_a, adder_b, bus_out, bus_drive, acc, carry_flag, zero_flag, busy, done
  );
  modport slave (
    input  bus_in, load_a, load_b, add_start, out_en, adder_s, adder_carry, sub,
    output adder_a, adder_b, bus_out, bus_drive, acc, carry_flag, zero_flag, busy, done
  );
`else
  modport master (
    output bus_in, load_a, load_b, add_start, out_en, adder_s, adder_carry,
    input  adder_a, adder_b, bus_out, bus_drive, acc, carry_flag, zero_flag, busy, done
  );
  modport slave (
    input  bus_in, load_a, load_b, add_start, out_en, adder_s, adder_carry,
    output adder_a, adder_b, bus_out, bus_drive, acc, carry_flag, zero_flag, busy, done
  );
`endif
endinterface

// File: rtl/sap1_accumulator_stage.sv
// SAP-1 operand stage: A/B registers feeding an external adder, 2-cycle add writeback,
// carry/zero flags. Optional subtract mode enabled by defining SAP1_ACC_SUBTRACT_EN.
module sap1_accumulator_stage #(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  sap1_accumulator_stage_if.slave io
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
`ifdef SAP1_ACC_SUBTRACT_EN
  logic             sub_q, sub_d;
`endif

  // NOTE: every next-state signal gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
`ifdef SAP1_ACC_SUBTRACT_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (io.load_a) a_d = io.bus_in;
        if (io.load_b) b_d = io.bus_in;
        // A load in the same cycle as add_start wins; the add request is dropped.
        if (io.add_start && !io.load_a && !io.load_b) begin
          state_d = EXEC;
`ifdef SAP1_ACC_SUBTRACT_EN
          sub_d   = io.sub;
`endif
        end
      end
      EXEC: begin
        a_d     = io.adder_s;
        zero_d  = (io.adder_s == '0);
`ifdef SAP1_ACC_SUBTRACT_EN
        // A + (-0) never carries out, yet subtracting zero never borrows.
        carry_d = io.adder_carry | (sub_q && (b_q == '0));
`else
        carry_d = io.adder_carry;
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SAP1_ACC_SUBTRACT_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
`ifdef SAP1_ACC_SUBTRACT_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign io.adder_a    = a_q;
`ifdef SAP1_ACC_SUBTRACT_EN
  assign io.adder_b    = (state_q == EXEC && sub_q) ? ('0 - b_q) : b_q;
`else
  assign io.adder_b    = b_q;
`endif
  assign io.bus_out    = io.out_en ? a_q : '0;
  assign io.bus_drive  = io.out_en;
  assign io.acc        = a_q;
  assign io.carry_flag = carry_q;
  assign io.zero_flag  = zero_q;
  assign io.busy       = (state_q == EXEC);
  assign io.done       = done_q;

endmodule

// File: tb/tb_sap1_accumulator_stage.sv
// Directed bench for sap1_accumulator_stage with an operation-level reference model
// and a per-cycle compare; the subtract cases run when SAP1_ACC_SUBTRACT_EN is defined.
module tb_sap1_accumulator_stage;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  sap1_accumulator_stage_if #(.WIDTH(WIDTH)) ifc ();

  sap1_accumulator_stage #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave)
  );

  always #5 clk = ~clk;

  // External 8-bit unsigned adder the stage is meant to drive.
  logic [WIDTH:0] adder_full;
  assign adder_full      = {1'b0, ifc.adder_a} + {1'b0, ifc.adder_b};
  assign ifc.adder_s     = adder_full[WIDTH-1:0];
  assign ifc.adder_carry = adder_full[WIDTH];

  int vectors    = 0;
  int miscompares = 0;
  bit check_en   = 1'b0;

  task automatic chk8(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending operation, computed with plain arithmetic on A and B.
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic             m_c = 1'b0, m_z = 1'b0, m_pending = 1'b0, m_done = 1'b0, m_sub = 1'b0;
  logic             sub_in;
  logic [WIDTH:0]   m_sum;

`ifdef SAP1_ACC_SUBTRACT_EN
  assign ifc.sub = sub_in;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_a = '0; m_b = '0; m_c = 1'b0; m_z = 1'b0;
      m_pending = 1'b0; m_done = 1'b0; m_sub = 1'b0;
    end else if (m_pending) begin
      if (m_sub) begin
        m_c = (m_a >= m_b);
        m_a = m_a - m_b;
      end else begin
        m_sum = {1'b0, m_a} + {1'b0, m_b};
        m_c   = m_sum[WIDTH];
        m_a   = m_sum[WIDTH-1:0];
      end
      m_z       = (m_a == 0);
      m_pending = 1'b0;
      m_done    = 1'b1;
    end else begin
      m_done = 1'b0;
      if (ifc.load_a) m_a = ifc.bus_in;
      if (ifc.load_b) m_b = ifc.bus_in;
      if (ifc.add_start && !ifc.load_a && !ifc.load_b) begin
        m_pending = 1'b1;
        m_sub     = sub_in;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk8("acc",        ifc.acc,        m_a);
      chk8("adder_a",    ifc.adder_a,    m_a);
      chk8("adder_b",    ifc.adder_b,    (m_pending && m_sub) ? WIDTH'(0 - m_b) : m_b);
      chk8("bus_out",    ifc.bus_out,    ifc.out_en ? m_a : '0);
      chk1("bus_drive",  ifc.bus_drive,  ifc.out_en);
      chk1("carry_flag", ifc.carry_flag, m_c);
      chk1("zero_flag",  ifc.zero_flag,  m_z);
      chk1("busy",       ifc.busy,       m_pending);
      chk1("done",       ifc.done,       m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.load_a = 1'b0; ifc.load_b = 1'b0; ifc.add_start = 1'b0;
    ifc.out_en = 1'b0; sub_in = 1'b0;
  endtask

  task automatic load_ab(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    ifc.bus_in = a; ifc.load_a = 1'b1; tick();
    ifc.load_a = 1'b0; ifc.bus_in = b; ifc.load_b = 1'b1; tick();
    ifc.load_b = 1'b0;
  endtask

  task automatic run_op(input logic s);
    sub_in = s; ifc.add_start = 1'b1; tick();
    ifc.add_start = 1'b0; sub_in = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1;
    ifc.bus_in = '0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    check_en = 1'b1;
    chk8("reset acc", ifc.acc, 8'h00);
    chk1("reset busy", ifc.busy, 1'b0);

    // 01 + 02
    load_ab(8'h01, 8'h02);
    ifc.add_start = 1'b1; tick();
    ifc.add_start = 1'b0;
    chk1("add1 busy", ifc.busy, 1'b1);
    tick();
    chk8("add1 acc", ifc.acc, 8'h03);
    chk1("add1 done", ifc.done, 1'b1);
    chk1("add1 carry", ifc.carry_flag, 1'b0);
    chk1("add1 zero", ifc.zero_flag, 1'b0);
    tick();
    chk1("add1 done drop", ifc.done, 1'b0);

    // FF + 01 wraps to zero with carry
    load_ab(8'hFF, 8'h01);
    run_op(1'b0);
    chk8("wrap acc", ifc.acc, 8'h00);
    chk1("wrap carry", ifc.carry_flag, 1'b1);
    chk1("wrap zero", ifc.zero_flag, 1'b1);
    ifc.out_en = 1'b1; #1;
    chk8("wrap bus_out", ifc.bus_out, 8'h00);
    chk1("wrap bus_drive", ifc.bus_drive, 1'b1);
    tick(); ifc.out_en = 1'b0;

    // add_start held: one add per two cycles
    load_ab(8'h0F, 8'h01);
    ifc.add_start = 1'b1;
    tick(); chk1("b2b busy", ifc.busy, 1'b1);
    tick(); chk8("b2b acc1", ifc.acc, 8'h10); chk1("b2b done1", ifc.done, 1'b1);
    tick(); chk1("b2b gap", ifc.done, 1'b0);
    tick(); chk8("b2b acc2", ifc.acc, 8'h11); chk1("b2b done2", ifc.done, 1'b1);
    ifc.add_start = 1'b0;
    tick();

    // Loads ignored during EXEC; bus_out shows old A there; load beats add_start in IDLE
    load_ab(8'h0A, 8'h05);
    ifc.add_start = 1'b1; tick();
    ifc.add_start = 1'b0; ifc.load_a = 1'b1; ifc.bus_in = 8'h77; ifc.out_en = 1'b1; #1;
    chk8("exec bus_out", ifc.bus_out, 8'h0A);
    tick();
    chk8("exec load ignored", ifc.acc, 8'h0F);
    ifc.add_start = 1'b1; ifc.out_en = 1'b0;
    tick();
    ifc.load_a = 1'b0; ifc.add_start = 1'b0;
    chk8("load wins", ifc.acc, 8'h77);
    chk1("load wins busy", ifc.busy, 1'b0);
    tick();

    // Reset abandons an add in flight
    load_ab(8'hC0, 8'h50);
    run_op(1'b0);
    ifc.add_start = 1'b1; tick();
    ifc.add_start = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    chk8("rst acc", ifc.acc, 8'h00);
    chk8("rst b", ifc.adder_b, 8'h00);
    chk1("rst carry", ifc.carry_flag, 1'b0);
    chk1("rst busy", ifc.busy, 1'b0);
    tick();
    chk1("rst no done", ifc.done, 1'b0);

`ifdef SAP1_ACC_SUBTRACT_EN
    load_ab(8'h05, 8'h03); run_op(1'b1);
    chk8("sub1 acc", ifc.acc, 8'h02); chk1("sub1 carry", ifc.carry_flag, 1'b1);
    load_ab(8'h03, 8'h05); run_op(1'b1);
    chk8("sub2 acc", ifc.acc, 8'hFE); chk1("sub2 carry", ifc.carry_flag, 1'b0);
    load_ab(8'h03, 8'h00); run_op(1'b1);
    chk8("sub3 acc", ifc.acc, 8'h03); chk1("sub3 carry", ifc.carry_flag, 1'b1);
    tick();
`endif

    // Plain add after all the above, both operands loaded at once
    ifc.bus_in = 8'h40; ifc.load_a = 1'b1; ifc.load_b = 1'b1; tick();
    idle_inputs();
    run_op(1'b0);
    chk8("dual load add", ifc.acc, 8'h80);
    tick();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
